// File: rtl/step_profile_pkg.sv
// Shared state encoding and default profile constants for the step profile generator.
package step_profile_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_STEP_W       = 16;
  localparam int DEF_PER_W        = 20;
  localparam int DEF_START_PERIOD = 50000;
  localparam int DEF_MIN_PERIOD   = 5000;
  localparam int DEF_ACCEL_DEC    = 500;

endpackage

// File: rtl/step_profile_if.sv
// Move command handshake plus motor/status outputs of step_profile_gen.
// master drives commands and abort; slave is the profile generator.
interface step_profile_if #(
  parameter int STEP_W = step_profile_pkg::DEF_STEP_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic              abort;
  logic              motor_en;
  logic              motor_dir;
  logic              step_tick;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, abort,
    input  cmd_ready, motor_en, motor_dir, step_tick, busy, done, aborted, steps_left
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, abort,
    output cmd_ready, motor_en, motor_dir, step_tick, busy, done, aborted, steps_left
  );
endinterface

// File: rtl/step_profile_gen_timer.sv
// Step period counter: hit is high in the cycle where count reaches period-1.
// The count restarts on a command accept, on every hit, and whenever not running.
module step_tick_timer
  import step_profile_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  output logic             hit
);

  logic [PER_W-1:0] count;

  assign hit = run && (count == period - PER_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || hit || !run) begin
      count <= '0;
    end else begin
      count <= count + PER_W'(1);
    end
  end

endmodule

// File: rtl/step_profile_gen.sv
// Trapezoidal step profile: accelerate, cruise, decelerate, one step_tick per step.
// All outputs registered; done coincides with the final step_tick, or follows abort by one edge.
module step_profile_gen
  import step_profile_pkg::*;
#(
  parameter int STEP_W       = DEF_STEP_W,
  parameter int PER_W        = DEF_PER_W,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int ACCEL_DEC    = DEF_ACCEL_DEC
) (
  input logic         clk,
  input logic         rst,
  step_profile_if.slave bus
);

  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] DEC_P   = PER_W'(ACCEL_DEC);
  localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
  localparam logic [PER_W:0]   MIN_X   = (PER_W+1)'(MIN_PERIOD);
  localparam logic [PER_W:0]   DEC_X   = (PER_W+1)'(ACCEL_DEC);

  state_t            state, state_d;
  logic [PER_W-1:0]  cur_period, period_d, period_sat;
  logic [PER_W:0]    period_up;
  logic [STEP_W-1:0] ramp_cnt, ramp_d, steps_d, steps_dec;
  logic              dir_d, accept, moving, tick, near_min, end_zero, end_abort;
  logic              ready_d, en_d, done_d;

  assign moving    = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign end_zero  = accept && (bus.cmd_steps == '0);
  assign end_abort = moving && bus.abort;
  assign steps_dec = bus.steps_left - STEP_W'(1);

  // Extra bit keeps the ramp arithmetic free of wrap-around at either end.
  assign period_up  = {1'b0, cur_period} + DEC_X;
  assign period_sat = (period_up >= START_X) ? START_P : cur_period + DEC_P;
  assign near_min   = ({1'b0, cur_period} <= MIN_X + DEC_X);

  step_tick_timer #(.PER_W(PER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .run     (moving),
    .period  (cur_period),
    .hit     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    period_d = cur_period;
    ramp_d   = ramp_cnt;
    steps_d  = bus.steps_left;
    dir_d    = bus.motor_dir;
    unique case (state)
      IDLE: begin
        if (accept) begin
          dir_d   = bus.cmd_dir;
          steps_d = bus.cmd_steps;
          if (bus.cmd_steps != '0) begin
            state_d  = ACCEL;
            period_d = START_P;
            ramp_d   = '0;
          end
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (tick) begin
          steps_d = steps_dec;
          if (steps_dec == '0) begin
            state_d = DONE;
          end else if (state != DECEL && steps_dec <= ramp_cnt) begin
            // Remaining steps only cover the ramp already climbed: start braking.
            state_d  = DECEL;
            period_d = period_sat;
          end else if (state == ACCEL) begin
            ramp_d = ramp_cnt + STEP_W'(1);
            if (near_min) begin
              period_d = MIN_P;
              state_d  = CRUISE;
            end else begin
              period_d = cur_period - DEC_P;
            end
          end else if (state == DECEL) begin
            period_d = period_sat;
          end
        end
        if (bus.abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == IDLE);
    en_d    = (state_d == ACCEL) || (state_d == CRUISE) || (state_d == DECEL);
    done_d  = (state_d == DONE) || end_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_period     <= '0;
      ramp_cnt       <= '0;
      bus.steps_left <= '0;
      bus.motor_dir  <= 1'b0;
      bus.cmd_ready  <= 1'b0;
      bus.motor_en   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.step_tick  <= 1'b0;
      bus.done       <= 1'b0;
      bus.aborted    <= 1'b0;
    end else begin
      cur_period     <= period_d;
      ramp_cnt       <= ramp_d;
      bus.steps_left <= steps_d;
      bus.motor_dir  <= dir_d;
      bus.cmd_ready  <= ready_d;
      bus.motor_en   <= en_d;
      bus.busy       <= en_d;
      bus.step_tick  <= tick;
      bus.done       <= done_d;
      bus.aborted    <= end_abort;
    end
  end

endmodule
